// File: rtl/test_pattern_gen.sv
// Streams a full test-pattern frame (solid/box/checker/ramp) into a frame buffer, one beat per accept.
// Optional TPG_FRAME_COUNT_EN adds a 16-bit frame_count output counting frame_done pulses.
module test_pattern_gen #(
   parameter int unsigned H_ACTIVE    = 160,
   parameter int unsigned V_ACTIVE    = 120,
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned PIXEL_WIDTH = 1,
   parameter int unsigned BOX_X0      = 40,
   parameter int unsigned BOX_X1      = 119,
   parameter int unsigned BOX_Y0      = 30,
   parameter int unsigned BOX_Y1      = 89,
   parameter int unsigned CHECK_SHIFT = 3
) (
   input  logic                   clk_25,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic                   ready,
   output logic                   we,
   output logic [ADDR_WIDTH-1:0]  write_addr,
   output logic [PIXEL_WIDTH-1:0] pixel,
   output logic                   sof,
`ifdef TPG_FRAME_COUNT_EN
   output logic [15:0]            frame_count,
`endif
   output logic                   frame_done
);

   localparam int unsigned HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int unsigned VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state, state_nxt;
   logic [HW-1:0]          h, h_nxt;
   logic [VW-1:0]          v, v_nxt;
   logic [1:0]             mode_q, mode_q_nxt;
   logic                   we_nxt, sof_nxt, frame_done_nxt;
   logic [ADDR_WIDTH-1:0]  addr_nxt;
   logic [PIXEL_WIDTH-1:0] pixel_nxt;
   logic                   accept, last_beat;

   assign accept    = we & ready;
   assign last_beat = (h == HW'(H_ACTIVE - 1)) && (v == VW'(V_ACTIVE - 1));

   function automatic logic [PIXEL_WIDTH-1:0] pattern(input logic [1:0]    m,
                                                      input logic [HW-1:0] hh,
                                                      input logic [VW-1:0] vv);
      int unsigned            hi, vi;
      logic                   on;
      logic [PIXEL_WIDTH-1:0] ramp;
      hi   = 32'(hh);
      vi   = 32'(vv);
      ramp = '0;
      for (int unsigned i = 0; i < PIXEL_WIDTH; i++)
         if (i < HW) ramp[i] = hh[i];
      case (m)
         2'd0:    on = 1'b1;
         2'd1:    on = !(hi > BOX_X0 && hi < BOX_X1 && vi > BOX_Y0 && vi < BOX_Y1);
         2'd2:    on = (((hi >> CHECK_SHIFT) ^ (vi >> CHECK_SHIFT)) & 32'd1) != 32'd0;
         default: on = 1'b0;
      endcase
      if (m == 2'd3) return ramp;
      return {PIXEL_WIDTH{on}};
   endfunction

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enable) state_nxt = RUN;
         RUN:  if (accept && last_beat && !enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs; the pixel is computed from the
   // h/v it will be presented with so pixel and write_addr stay aligned.
   always_comb begin
      we_nxt         = we;
      addr_nxt       = write_addr;
      pixel_nxt      = pixel;
      sof_nxt        = sof;
      h_nxt          = h;
      v_nxt          = v;
      mode_q_nxt     = mode_q;
      frame_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            we_nxt  = 1'b0;
            sof_nxt = 1'b0;
            if (enable) begin
               we_nxt     = 1'b1;
               addr_nxt   = '0;
               h_nxt      = '0;
               v_nxt      = '0;
               sof_nxt    = 1'b1;
               mode_q_nxt = mode;
               pixel_nxt  = pattern(mode, '0, '0);
            end
         end
         RUN: begin
            if (accept) begin
               if (last_beat) begin
                  frame_done_nxt = 1'b1;
                  if (enable) begin
                     addr_nxt   = '0;
                     h_nxt      = '0;
                     v_nxt      = '0;
                     sof_nxt    = 1'b1;
                     mode_q_nxt = mode;
                     pixel_nxt  = pattern(mode, '0, '0);
                  end else begin
                     we_nxt  = 1'b0;
                     sof_nxt = 1'b0;
                  end
               end else begin
                  addr_nxt = write_addr + ADDR_WIDTH'(1);
                  sof_nxt  = 1'b0;
                  if (h == HW'(H_ACTIVE - 1)) begin
                     h_nxt = '0;
                     v_nxt = v + VW'(1);
                  end else begin
                     h_nxt = h + HW'(1);
                  end
                  pixel_nxt = pattern(mode_q, h_nxt, v_nxt);
               end
            end
         end
         default: we_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         we         <= 1'b0;
         write_addr <= '0;
         pixel      <= '0;
         sof        <= 1'b0;
         frame_done <= 1'b0;
         h          <= '0;
         v          <= '0;
         mode_q     <= '0;
      end else begin
         we         <= we_nxt;
         write_addr <= addr_nxt;
         pixel      <= pixel_nxt;
         sof        <= sof_nxt;
         frame_done <= frame_done_nxt;
         h          <= h_nxt;
         v          <= v_nxt;
         mode_q     <= mode_q_nxt;
      end
   end

`ifdef TPG_FRAME_COUNT_EN
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n)        frame_count <= '0;
      else if (frame_done) frame_count <= frame_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: a frame-level reference model queues expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_test_pattern_gen;

   localparam int unsigned H  = 160;
   localparam int unsigned V  = 120;
   localparam int unsigned AW = 15;
   localparam int unsigned PW = 1;
   localparam int unsigned N  = H * V;

   logic          clk_25 = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          ready = 1'b0;
   logic          we;
   logic [AW-1:0] write_addr;
   logic [PW-1:0] pixel;
   logic          sof;
   logic          frame_done;

   test_pattern_gen #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW),
      .BOX_X0(40), .BOX_X1(119), .BOX_Y0(30), .BOX_Y1(89), .CHECK_SHIFT(3)
   ) dut (
      .clk_25(clk_25), .reset_n(reset_n), .enable(enable), .mode(mode), .ready(ready),
      .we(we), .write_addr(write_addr), .pixel(pixel), .sof(sof), .frame_done(frame_done)
   );

   always #5 clk_25 = ~clk_25;

   typedef struct {
      int unsigned addr;
      bit          pix;
      bit          sof;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_fd  = 0;

   bit          m_busy = 0;
   bit          m_fd   = 0;
   int unsigned m_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_pixel(input logic [1:0] m, input int unsigned k);
      int unsigned hh, vv;
      hh = k % H;
      vv = k / H;
      case (m)
         2'd0:    return 1'b1;
         2'd1:    return !(hh > 40 && hh < 119 && vv > 30 && vv < 89);
         2'd2:    return ((hh / 8) % 2) != ((vv / 8) % 2);
         default: return (hh % 2) == 1;
      endcase
   endfunction

   task automatic queue_frame(input logic [1:0] m);
      for (int unsigned k = 0; k < N; k++)
         exp_q.push_back('{addr: k, pix: ref_pixel(m, k), sof: (k == 0)});
   endtask

   // Frame-level model: a frame is N accepted beats, mode fixed at its start.
   always @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         m_busy = 0;
         m_fd   = 0;
         m_left = 0;
      end else begin
         m_fd = 0;
         if (m_busy) begin
            if (ready) begin
               m_left--;
               if (m_left == 0) begin
                  m_fd = 1;
                  if (enable) begin
                     queue_frame(mode);
                     m_left = N;
                  end else begin
                     m_busy = 0;
                  end
               end
            end
         end else if (enable) begin
            queue_frame(mode);
            m_busy = 1;
            m_left = N;
         end
      end
   end

   always @(negedge clk_25) begin
      if (reset_n) begin
         chk("we", 32'(we), 32'(m_busy));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         if (frame_done) n_fd++;
         if (we && ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(write_addr), 32'hFFFF_FFFF);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("write_addr", 32'(write_addr), e.addr);
               chk("pixel", 32'(pixel), 32'(e.pix));
               chk("sof", 32'(sof), 32'(e.sof));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_25);
      #2;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, 32'(we), 32'd0);
      chk({tag, "_addr"}, 32'(write_addr), 32'd0);
      chk({tag, "_pixel"}, 32'(pixel), 32'd0);
      chk({tag, "_sof"}, 32'(sof), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      check_zero("reset");

      // Frame A: box pattern, ready always high; mode changed to checker mid-frame.
      enable  = 1'b1;
      mode    = 2'd1;
      ready   = 1'b1;
      reset_n = 1'b1;
      repeat (5000) tick();
      mode = 2'd2;
      repeat (14300) tick();

      // Frame B (checker): ready toggles every cycle, enable dropped early, mode change ignored.
      for (int i = 0; i < 38600; i++) begin
         ready = ~ready;
         if (i == 200) enable = 1'b0;
         if (i == 300) mode = 2'd3;
         tick();
      end
      ready = 1'b1;
      repeat (20) tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("frames_done", n_fd, 32'd2);

      // Frame C: ramp with random ready, abandoned by an asynchronous reset.
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(3) != 0);
         tick();
      end
      reset_n = 1'b0;
      #1;
      check_zero("async_reset");
      enable = 1'b0;
      repeat (2) tick();
      check_zero("reset_hold");

      // Restart after reset: solid white, random ready.
      enable  = 1'b1;
      mode    = 2'd0;
      reset_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         ready = ($urandom_range(3) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
